// File: rtl/wr_dispatch.sv
// wr_dispatch: buffers worker results and routes each one, in arrival order,
// to the matching unit (LEFT/RIGHT), to fetch (ONE), or drops it (NONE).
// Ports: CLK/RST; RECEIVE_WR_* input stream (READY registered);
//   SEND_MT_* and SEND_FT_* output streams; DROP_COUNT saturating NONE counter.
module wr_dispatch #(
  parameter int DATA_WIDTH          = 32,
  parameter int COLOR_WIDTH         = 16,
  parameter int DEST_ADDR_WIDTH     = 10,
  parameter int DEST_OPTION_WIDTH   = 2,
  parameter int FIFO_DEPTH          = 4,
  parameter int WORKER_RESULT_WIDTH =
    DEST_OPTION_WIDTH + DEST_ADDR_WIDTH + COLOR_WIDTH + DATA_WIDTH
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic                           RECEIVE_WR_VALID,
  input  logic [WORKER_RESULT_WIDTH-1:0] RECEIVE_WR_DATA,
  output logic                           RECEIVE_WR_READY,
  output logic                           SEND_MT_VALID,
  output logic [WORKER_RESULT_WIDTH-1:0] SEND_MT_DATA,
  input  logic                           SEND_MT_READY,
  output logic                           SEND_FT_VALID,
  output logic [WORKER_RESULT_WIDTH-1:0] SEND_FT_DATA,
  input  logic                           SEND_FT_READY,
  output logic [15:0]                    DROP_COUNT
);

  localparam int WRW = WORKER_RESULT_WIDTH;
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CW  = PW + 1;
  localparam int OW  = DEST_OPTION_WIDTH;

  localparam logic [OW-1:0] OPT_LEFT  = OW'(1);
  localparam logic [OW-1:0] OPT_RIGHT = OW'(2);
  localparam logic [OW-1:0] OPT_ONE   = OW'(3);

  typedef enum logic {S_LOAD, S_SEND} state_t;

  logic [WRW-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]  wptr_q, wptr_d;
  logic [PW-1:0]  rptr_q, rptr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           rdy_q, rdy_d;
  state_t         state_q, state_d;
  logic           mt_v_q, mt_v_d;
  logic           ft_v_q, ft_v_d;
  logic [WRW-1:0] mt_data_q, mt_data_d;
  logic [WRW-1:0] ft_data_q, ft_data_d;
  logic [15:0]    drop_q, drop_d;

  logic           push;
  logic           pop;
  logic [WRW-1:0] head;
  logic [OW-1:0]  head_opt;

  assign push     = RECEIVE_WR_VALID && rdy_q;
  assign pop      = (state_q == S_LOAD) && (cnt_q != '0);
  assign head     = mem_q[rptr_q];
  assign head_opt = head[WRW-1 -: OW];

  // FIFO bookkeeping; pointers wrap naturally since depth is a power of 2.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push) wptr_d = wptr_q + PW'(1);
    if (pop)  rptr_d = rptr_q + PW'(1);
    cnt_d = cnt_q + CW'(push) - CW'(pop);
    // READY looks one edge ahead so a full FIFO never sees a push.
    rdy_d = (cnt_d < CW'(FIFO_DEPTH));
  end

  always_comb begin
    state_d   = state_q;
    mt_v_d    = mt_v_q;
    ft_v_d    = ft_v_q;
    mt_data_d = mt_data_q;
    ft_data_d = ft_data_q;
    drop_d    = drop_q;
    case (state_q)
      S_LOAD: begin
        if (pop) begin
          if (head_opt == OPT_LEFT || head_opt == OPT_RIGHT) begin
            mt_data_d = head;
            mt_v_d    = 1'b1;
            state_d   = S_SEND;
          end else if (head_opt == OPT_ONE) begin
            ft_data_d = head;
            ft_v_d    = 1'b1;
            state_d   = S_SEND;
          end else if (drop_q != 16'hFFFF) begin
            drop_d = drop_q + 16'd1;
          end
        end
      end
      S_SEND: begin
        if (mt_v_q && SEND_MT_READY) begin
          mt_v_d  = 1'b0;
          state_d = S_LOAD;
        end else if (ft_v_q && SEND_FT_READY) begin
          ft_v_d  = 1'b0;
          state_d = S_LOAD;
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (push) mem_q[wptr_q] <= RECEIVE_WR_DATA;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      cnt_q     <= '0;
      rdy_q     <= 1'b0;
      state_q   <= S_LOAD;
      mt_v_q    <= 1'b0;
      ft_v_q    <= 1'b0;
      mt_data_q <= '0;
      ft_data_q <= '0;
      drop_q    <= '0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      cnt_q     <= cnt_d;
      rdy_q     <= rdy_d;
      state_q   <= state_d;
      mt_v_q    <= mt_v_d;
      ft_v_q    <= ft_v_d;
      mt_data_q <= mt_data_d;
      ft_data_q <= ft_data_d;
      drop_q    <= drop_d;
    end
  end

  assign RECEIVE_WR_READY = rdy_q;
  assign SEND_MT_VALID    = mt_v_q;
  assign SEND_MT_DATA     = mt_data_q;
  assign SEND_FT_VALID    = ft_v_q;
  assign SEND_FT_DATA     = ft_data_q;
  assign DROP_COUNT       = drop_q;

endmodule

// File: tb/tb_wr_dispatch.sv
// tb_wr_dispatch: directed and randomized checks of wr_dispatch routing,
// backpressure, drop counting, reset and in-order delivery.
module tb_wr_dispatch;

  localparam int WRW = 60;

  logic           CLK = 1'b0;
  logic           RST = 1'b1;
  logic           RECEIVE_WR_VALID = 1'b0;
  logic [WRW-1:0] RECEIVE_WR_DATA = '0;
  logic           RECEIVE_WR_READY;
  logic           SEND_MT_VALID;
  logic [WRW-1:0] SEND_MT_DATA;
  logic           SEND_MT_READY = 1'b0;
  logic           SEND_FT_VALID;
  logic [WRW-1:0] SEND_FT_DATA;
  logic           SEND_FT_READY = 1'b0;
  logic [15:0]    DROP_COUNT;

  wr_dispatch dut (
    .CLK              (CLK),
    .RST              (RST),
    .RECEIVE_WR_VALID (RECEIVE_WR_VALID),
    .RECEIVE_WR_DATA  (RECEIVE_WR_DATA),
    .RECEIVE_WR_READY (RECEIVE_WR_READY),
    .SEND_MT_VALID    (SEND_MT_VALID),
    .SEND_MT_DATA     (SEND_MT_DATA),
    .SEND_MT_READY    (SEND_MT_READY),
    .SEND_FT_VALID    (SEND_FT_VALID),
    .SEND_FT_DATA     (SEND_FT_DATA),
    .SEND_FT_READY    (SEND_FT_READY),
    .DROP_COUNT       (DROP_COUNT)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_err = 0;
  int exp_drops = 0;
  bit rand_rdy = 0;

  logic [WRW:0] exp_q[$];
  logic [WRW:0] got_q[$];

  logic           mt_stall = 0;
  logic           ft_stall = 0;
  logic [WRW-1:0] mt_prev = '0;
  logic [WRW-1:0] ft_prev = '0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic logic [WRW-1:0] mk(input logic [1:0] o,
                                        input logic [9:0] a,
                                        input logic [15:0] c,
                                        input logic [31:0] d);
    return {o, a, c, d};
  endfunction

  always @(negedge CLK) begin
    if (RST) begin
      mt_stall = 0;
      ft_stall = 0;
    end else begin
      if (SEND_MT_VALID || SEND_FT_VALID)
        check("one_hot", 64'(SEND_MT_VALID & SEND_FT_VALID), 64'd0);
      if (mt_stall) begin
        check("mt_hold_v", 64'(SEND_MT_VALID), 64'd1);
        check("mt_hold_d", 64'(SEND_MT_DATA), 64'(mt_prev));
      end
      if (ft_stall) begin
        check("ft_hold_v", 64'(SEND_FT_VALID), 64'd1);
        check("ft_hold_d", 64'(SEND_FT_DATA), 64'(ft_prev));
      end
      if (SEND_MT_VALID && SEND_MT_READY) got_q.push_back({1'b0, SEND_MT_DATA});
      if (SEND_FT_VALID && SEND_FT_READY) got_q.push_back({1'b1, SEND_FT_DATA});
      mt_stall = SEND_MT_VALID && !SEND_MT_READY;
      ft_stall = SEND_FT_VALID && !SEND_FT_READY;
      mt_prev  = SEND_MT_DATA;
      ft_prev  = SEND_FT_DATA;
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
    if (rand_rdy) begin
      SEND_MT_READY = ($urandom_range(0, 3) != 0);
      SEND_FT_READY = ($urandom_range(0, 3) != 0);
    end
  endtask

  // Offer one result, hold it until accepted; leaves VALID high.
  task automatic offer(input logic [WRW-1:0] r);
    int   n;
    logic acc;
    n = 0;
    RECEIVE_WR_VALID = 1'b1;
    RECEIVE_WR_DATA  = r;
    do begin
      acc = RECEIVE_WR_READY;
      step();
      n++;
    end while (!acc && n < 200);
    check("offer_accept", 64'(acc), 64'd1);
    if (acc) begin
      if (r[WRW-1 -: 2] == 2'b00) exp_drops++;
      else exp_q.push_back({r[WRW-1 -: 2] == 2'b11, r});
    end
  endtask

  task automatic idle(input int n);
    RECEIVE_WR_VALID = 1'b0;
    repeat (n) step();
  endtask

  task automatic wait_got(input int n, input int max_cyc);
    int c;
    c = 0;
    while (got_q.size() < n && c < max_cyc) begin
      step();
      c++;
    end
    check("drain_count", 64'(got_q.size()), 64'(n));
  endtask

  task automatic compare_all(input string tag);
    int n;
    check({tag, "_size"}, 64'(got_q.size()), 64'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check(tag, 64'(got_q[i]), 64'(exp_q[i]));
  endtask

  task automatic clear_sb();
    exp_q.delete();
    got_q.delete();
    exp_drops = 0;
  endtask

  logic [WRW-1:0] ra, rb;
  logic [WRW-1:0] rl [5];

  initial begin
    // Reset state
    #1;
    check("rst_ready", 64'(RECEIVE_WR_READY), 64'd0);
    check("rst_mt_v", 64'(SEND_MT_VALID), 64'd0);
    check("rst_ft_v", 64'(SEND_FT_VALID), 64'd0);
    check("rst_mt_d", 64'(SEND_MT_DATA), 64'd0);
    check("rst_ft_d", 64'(SEND_FT_DATA), 64'd0);
    check("rst_drop", 64'(DROP_COUNT), 64'd0);
    @(negedge CLK);
    #2 RST = 1'b0;
    #1 check("rst_ready_hold", 64'(RECEIVE_WR_READY), 64'd0);
    step();
    check("ready_after_rel", 64'(RECEIVE_WR_READY), 64'd1);

    // Routing: LEFT to MT, then ONE to FT, 2 cycles apart
    clear_sb();
    SEND_MT_READY = 1'b1;
    SEND_FT_READY = 1'b1;
    ra = mk(2'b01, 10'h005, 16'h0001, 32'h0000000A);
    rb = mk(2'b11, 10'h006, 16'h0001, 32'h00000007);
    offer(ra);
    offer(rb);
    RECEIVE_WR_VALID = 1'b0;
    check("t2_mt_v", 64'(SEND_MT_VALID), 64'd1);
    check("t2_mt_d", 64'(SEND_MT_DATA), 64'(ra));
    check("t2_ft_v0", 64'(SEND_FT_VALID), 64'd0);
    step();
    check("t2_mt_v_clr", 64'(SEND_MT_VALID), 64'd0);
    check("t2_ft_v_gap", 64'(SEND_FT_VALID), 64'd0);
    step();
    check("t2_ft_v", 64'(SEND_FT_VALID), 64'd1);
    check("t2_ft_d", 64'(SEND_FT_DATA), 64'(rb));
    check("t2_mt_d_keep", 64'(SEND_MT_DATA), 64'(ra));
    step();
    check("t2_ft_v_clr", 64'(SEND_FT_VALID), 64'd0);
    compare_all("t2_order");

    // Backpressure: MT stalled; one result sits on MT, four fill the FIFO
    clear_sb();
    SEND_MT_READY = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rl[i] = mk(2'b01, 10'(i + 16), 16'h00A0, 32'hC0DE0000 + 32'(i));
      offer(rl[i]);
    end
    RECEIVE_WR_VALID = 1'b0;
    check("t3_full_ready", 64'(RECEIVE_WR_READY), 64'd0);
    check("t3_mt_v", 64'(SEND_MT_VALID), 64'd1);
    check("t3_mt_d", 64'(SEND_MT_DATA), 64'(rl[0]));
    idle(3);
    check("t3_still_full", 64'(RECEIVE_WR_READY), 64'd0);
    check("t3_mt_d_stable", 64'(SEND_MT_DATA), 64'(rl[0]));
    check("t3_none_out", 64'(got_q.size()), 64'd0);
    SEND_MT_READY = 1'b1;
    wait_got(5, 40);
    idle(3);
    compare_all("t3_order");
    check("t3_ready_back", 64'(RECEIVE_WR_READY), 64'd1);
    check("t3_mt_v_idle", 64'(SEND_MT_VALID), 64'd0);

    // Drop: NONE results vanish and are counted
    clear_sb();
    ra = mk(2'b10, 10'h100, 16'h0002, 32'h11111111);
    rb = mk(2'b10, 10'h101, 16'h0002, 32'h22222222);
    offer(ra);
    for (int i = 0; i < 3; i++)
      offer(mk(2'b00, 10'(i), 16'h0003, 32'hDEAD0000 + 32'(i)));
    offer(rb);
    idle(1);
    wait_got(2, 40);
    idle(4);
    compare_all("t4_order");
    check("t4_drop3", 64'(DROP_COUNT), 64'd3);
    force dut.drop_q = 16'hFFFF;
    #1 check("t4_forced", 64'(DROP_COUNT), 64'hFFFF);
    @(negedge CLK);
    release dut.drop_q;
    step();
    offer(mk(2'b00, 10'h3FF, 16'hFFFF, 32'hFFFFFFFF));
    idle(4);
    check("t4_saturate", 64'(DROP_COUNT), 64'hFFFF);

    // Async reset mid-transfer
    clear_sb();
    SEND_MT_READY = 1'b0;
    offer(mk(2'b01, 10'h0AA, 16'h5555, 32'h12345678));
    idle(2);
    check("t1_pre_mt_v", 64'(SEND_MT_VALID), 64'd1);
    #2 RST = 1'b1;
    #1;
    check("t1_mt_v", 64'(SEND_MT_VALID), 64'd0);
    check("t1_mt_d", 64'(SEND_MT_DATA), 64'd0);
    check("t1_ready", 64'(RECEIVE_WR_READY), 64'd0);
    check("t1_drop", 64'(DROP_COUNT), 64'd0);
    check("t1_ft_v", 64'(SEND_FT_VALID), 64'd0);
    @(negedge CLK);
    #2 RST = 1'b0;
    #1 check("t1_ready_rel", 64'(RECEIVE_WR_READY), 64'd0);
    step();
    check("t1_ready_edge", 64'(RECEIVE_WR_READY), 64'd1);
    SEND_MT_READY = 1'b1;
    clear_sb();
    idle(4);
    check("t1_lost", 64'(got_q.size()), 64'd0);

    // Random mix: in-order delivery across wrap and same-edge push/pop
    clear_sb();
    rand_rdy = 1;
    for (int i = 0; i < 1000; i++) begin
      offer(mk(2'($urandom_range(0, 3)), 10'($urandom), 16'($urandom),
               32'($urandom)));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    RECEIVE_WR_VALID = 1'b0;
    rand_rdy = 0;
    SEND_MT_READY = 1'b1;
    SEND_FT_READY = 1'b1;
    wait_got(exp_q.size(), 200);
    idle(4);
    compare_all("t5_order");
    check("t5_drops", 64'(DROP_COUNT), 64'(exp_drops));
    check("t5_ready", 64'(RECEIVE_WR_READY), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
